// File: rtl/fifo_ctrl_128_32_pkg.sv
// Shared constants and helpers for the 128x32 RAM-backed FIFO controller.
package fifo_ctrl_128_32_pkg;

   localparam int unsigned FIFO_AW        = 7;
   localparam int unsigned FIFO_DW        = 32;
   localparam int unsigned FIFO_DEPTH     = 128;
   localparam int unsigned FIFO_BUF_DEPTH = 2;
   localparam int unsigned FIFO_LW        = 8;
   localparam int unsigned FIFO_BCW       = $clog2(FIFO_BUF_DEPTH + 1);

   // True when the output buffer can take one more read after this cycle's pop.
   function automatic logic buf_room(input logic [FIFO_BCW-1:0] cnt,
                                     input logic                 inflight,
                                     input logic                 pop);
      int unsigned occ;
      occ = 32'(cnt) + 32'(inflight);
      return occ < (32'(pop) + FIFO_BUF_DEPTH);
   endfunction

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer that hides the RAM read latency; fill and pop may
// happen in the same cycle.
module fifo_out_buf
   import fifo_ctrl_128_32_pkg::*;
#(
   parameter int unsigned DW = FIFO_DW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                fill,
   input  logic [DW-1:0]       fill_data,
   input  logic                pop,
   output logic [DW-1:0]       head_data,
   output logic                head_valid,
   output logic [FIFO_BCW-1:0] cnt
);

   logic [DW-1:0]       mem_q [FIFO_BUF_DEPTH];
   logic                wr_ptr_q;
   logic                rd_ptr_q;
   logic [FIFO_BCW-1:0] cnt_q;
   logic [FIFO_BCW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (flush) begin
         cnt_d = '0;
      end else begin
         unique case ({fill, pop})
            2'b10:   cnt_d = cnt_q + FIFO_BCW'(1);
            2'b01:   cnt_d = cnt_q - FIFO_BCW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            if (fill) begin
               mem_q[wr_ptr_q] <= fill_data;
               wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
               rd_ptr_q <= ~rd_ptr_q;
            end
         end
      end
   end

   assign head_data  = mem_q[rd_ptr_q];
   assign head_valid = (cnt_q != '0);
   assign cnt        = cnt_q;

endmodule

// File: rtl/fifo_ctrl_128_32.sv
// Controller turning an external 1R1W registered-read RAM into a 128-entry FIFO.
// Define FIFO_CTRL_BYPASS_EN to let pushes into an idle FIFO skip the RAM.
module fifo_ctrl_128_32
   import fifo_ctrl_128_32_pkg::*;
#(
   parameter int unsigned AW = FIFO_AW,
   parameter int unsigned DW = FIFO_DW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [DW-1:0]      in_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DW-1:0]      out_data,
   input  logic               flush,
   output logic [FIFO_LW-1:0] level,
   output logic [AW-1:0]      ram_waddr,
   output logic [DW-1:0]      ram_wr,
   output logic               ram_we,
   output logic [AW-1:0]      ram_raddr,
   output logic               ram_re,
   input  logic [DW-1:0]      ram_rd
);

   localparam logic [FIFO_LW-1:0] FullCnt = FIFO_LW'(2 ** AW);

   logic [AW-1:0]       wptr_q, wptr_d;
   logic [AW-1:0]       rptr_q, rptr_d;
   logic [FIFO_LW-1:0]  ram_cnt_q, ram_cnt_d;
   logic                inflight_q, inflight_d;
   logic                in_ready_q, in_ready_d;

   logic                push;
   logic                pop;
   logic                issue;
   logic                bypass;
   logic                push_ram;
   logic                fill;
   logic [DW-1:0]       fill_data;
   logic [FIFO_BCW-1:0] buf_cnt;
   logic                buf_valid;
   logic [DW-1:0]       buf_head;

   // Handshakes; flush wins over every transfer in its cycle.
   always_comb begin
      push = in_valid & in_ready_q & ~flush;
      pop  = buf_valid & out_ready & ~flush;
`ifdef FIFO_CTRL_BYPASS_EN
      // Safe for ordering: nothing older sits in RAM or in flight.
      bypass = push & (ram_cnt_q == '0) & ~inflight_q & buf_room(buf_cnt, 1'b0, pop);
`else
      bypass = 1'b0;
`endif
      push_ram = push & ~bypass;
      // Only entries committed on an earlier edge are read, so no RAW collision.
      issue = ~flush & (ram_cnt_q != '0) & buf_room(buf_cnt, inflight_q, pop);
      // A returning read and a bypass push are mutually exclusive.
      fill      = (inflight_q | bypass) & ~flush;
      fill_data = inflight_q ? ram_rd : in_data;
   end

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      ram_cnt_d  = ram_cnt_q;
      inflight_d = 1'b0;
      in_ready_d = 1'b1;
      if (flush) begin
         wptr_d    = '0;
         rptr_d    = '0;
         ram_cnt_d = '0;
      end else begin
         if (push_ram) begin
            wptr_d = wptr_q + AW'(1);
         end
         if (issue) begin
            rptr_d = rptr_q + AW'(1);
         end
         ram_cnt_d  = ram_cnt_q + FIFO_LW'(push_ram) - FIFO_LW'(issue);
         inflight_d = issue;
         in_ready_d = (ram_cnt_d != FullCnt);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         ram_cnt_q  <= '0;
         inflight_q <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         ram_cnt_q  <= ram_cnt_d;
         inflight_q <= inflight_d;
         in_ready_q <= in_ready_d;
      end
   end

   fifo_out_buf #(
      .DW (DW)
   ) u_out_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .fill       (fill),
      .fill_data  (fill_data),
      .pop        (pop),
      .head_data  (buf_head),
      .head_valid (buf_valid),
      .cnt        (buf_cnt)
   );

   assign ram_we    = push_ram;
   assign ram_waddr = wptr_q;
   assign ram_wr    = in_data;
   assign ram_re    = issue;
   assign ram_raddr = rptr_q;

   assign in_ready  = in_ready_q;
   assign out_valid = buf_valid;
   assign out_data  = buf_head;
   assign level     = ram_cnt_q + FIFO_LW'(inflight_q) + FIFO_LW'(buf_cnt);

   a_no_collision : assert property (@(posedge clk) disable iff (!rst)
      !(ram_we && ram_re && (ram_waddr == ram_raddr)));
   a_cnt_bound : assert property (@(posedge clk) disable iff (!rst)
      ram_cnt_q <= FullCnt);
   a_buf_bound : assert property (@(posedge clk) disable iff (!rst)
      32'(buf_cnt) <= FIFO_BUF_DEPTH);

endmodule

// File: tb/tb_fifo_ctrl_128_32.sv
// Randomized self-checking bench for fifo_ctrl_128_32 with a behavioural RAM and
// a queue-based reference model.
module tb_fifo_ctrl_128_32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        flush;
   logic [7:0]  level;
   logic [6:0]  ram_waddr;
   logic [31:0] ram_wr;
   logic        ram_we;
   logic [6:0]  ram_raddr;
   logic        ram_re;
   logic [31:0] ram_rd;

   logic [31:0] ram_mem [128];

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] model_q [$];
   int          cyc = 0;
   int          t_last_pop;
   logic [31:0] last_pop_data;
   logic        last_push;
   logic        s_in_ready;
   logic        s_out_valid;
   logic [7:0]  s_level;

`ifdef FIFO_CTRL_BYPASS_EN
   localparam int Lat = 1;
`else
   localparam int Lat = 3;
`endif

   fifo_ctrl_128_32 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .level     (level),
      .ram_waddr (ram_waddr),
      .ram_wr    (ram_wr),
      .ram_we    (ram_we),
      .ram_raddr (ram_raddr),
      .ram_re    (ram_re),
      .ram_rd    (ram_rd)
   );

   always #5 clk = ~clk;

   // ram_128_32 stand-in: synchronous write, registered read.
   always @(posedge clk) begin
      if (ram_we) ram_mem[ram_waddr] <= ram_wr;
      if (ram_re) ram_rd <= ram_mem[ram_raddr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called at posedge+1; drives one cycle, samples at negedge, updates the model.
   task automatic drive_cycle(input logic iv, input logic [31:0] d, input logic ordy,
                              input logic fl);
      logic push_ok, pop_ok;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
      s_in_ready  = in_ready;
      s_out_valid = out_valid;
      s_level     = level;
      check_eq("level", 32'(level), 32'(model_q.size()));
      check_eq("ram_collision", 32'(ram_re && ram_we && (ram_raddr == ram_waddr)), 32'd0);
      if (out_valid) begin
         check_eq("valid_nonempty", 32'(model_q.size() != 0), 32'd1);
         if (model_q.size() != 0) check_eq("head_data", out_data, model_q[0]);
      end
      push_ok   = iv && in_ready && !fl;
      pop_ok    = out_valid && ordy && !fl;
      last_push = push_ok;
      if (fl) begin
         model_q.delete();
      end else begin
         if (pop_ok && model_q.size() != 0) begin
            last_pop_data = model_q.pop_front();
            t_last_pop    = cyc;
         end
         if (push_ok) model_q.push_back(d);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      #1;
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_level", 32'(level), 32'd0);
      check_eq("rst_ram_we", 32'(ram_we), 32'd0);
      check_eq("rst_ram_re", 32'(ram_re), 32'd0);
      model_q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_in_ready_rise", 32'(in_ready), 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && model_q.size() != 0; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("drain_done", 32'(model_q.size()), 32'd0);
      drive_cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("drain_level", 32'(s_level), 32'd0);
      check_eq("drain_in_ready", 32'(s_in_ready), 32'd1);
   endtask

   task automatic fill_to(input int n);
      for (int i = 0; i < 500 && model_q.size() < n; i++)
         drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
      check_eq("fill_level", 32'(model_q.size()), 32'(n));
   endtask

   initial begin
      int t_push;
      int pushed;
      int pops;
      rst = 1'b1;
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0; in_data = '0;
      #3;
      do_reset();

      // 1: single-word latency
      t_last_pop = -100;
      drive_cycle(1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
      t_push = cyc - 1;
      for (int i = 0; i < 10 && model_q.size() != 0; i++) drive_cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("t1_latency", 32'(t_last_pop - t_push), 32'(Lat));
      check_eq("t1_data", last_pop_data, 32'hDEADBEEF);
      drain();

      // 2: fill to 130 with consumer stalled, then drain in order
      pushed = 0;
      for (int i = 0; i < 400 && pushed < 130; i++) begin
         drive_cycle(1'b1, 32'(pushed), 1'b0, 1'b0);
         if (last_push) pushed++;
      end
      check_eq("t2_accepts", 32'(pushed), 32'd130);
      drive_cycle(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      check_eq("t2_in_ready_low", 32'(s_in_ready), 32'd0);
      check_eq("t2_level_full", 32'(s_level), 32'd130);
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      drive_cycle(1'b0, '0, 1'b1, 1'b0);
      check_eq("t2_reopen", 32'(s_in_ready), 32'd1);
      drain();
      check_eq("t2_last", last_pop_data, 32'd129);

      // 3: streaming, one word per cycle once filled
      pops = 0;
      for (int i = 0; i < 300; i++) begin
         drive_cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
         if (i >= 5 && t_last_pop == cyc - 1) pops++;
      end
      check_eq("t3_rate", 32'(pops), 32'd295);
      drain();

      // 4: random handshakes, 1000 words
      pushed = 0;
      for (int i = 0; i < 10000 && pushed < 1000; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
         if (last_push) pushed++;
      end
      check_eq("t4_accepts", 32'(pushed), 32'd1000);
      drain();

      // 5: flush at level 40 discards a same-cycle push
      fill_to(40);
      drive_cycle(1'b1, 32'hBAD0_BAD0, 1'b0, 1'b1);
      drive_cycle(1'b0, '0, 1'b0, 1'b0);
      check_eq("t5_out_valid", 32'(s_out_valid), 32'd0);
      check_eq("t5_level", 32'(s_level), 32'd0);
      check_eq("t5_in_ready", 32'(s_in_ready), 32'd1);
      drive_cycle(1'b1, 32'h5, 1'b1, 1'b0);
      drain();
      check_eq("t5_next", last_pop_data, 32'h5);

      // 6: reset mid-stream at level 60, then resume from empty
      fill_to(60);
      do_reset();
      pushed = 0;
      for (int i = 0; i < 1000 && pushed < 50; i++) begin
         drive_cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
         if (last_push) pushed++;
      end
      check_eq("t6_accepts", 32'(pushed), 32'd50);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl_128_32.md
Name: fifo_ctrl_128_32

Overview:
Sequencing controller that turns one external ram_128_32 instance (1R1W, registered read, 1-cycle read latency) into a 128-entry synchronous FIFO with valid/ready handshakes on both sides. It owns the read/write pointers and the occupancy count. A 2-entry output buffer absorbs the RAM read latency, so the FIFO sustains 1 push plus 1 pop per cycle. It is used wherever the core needs deep 32-bit buffering, for example trace or uncached-store queues.

Parameters:
AW, 7, RAM address width; RAM depth is 2**AW = 128.
DW, 32, data width; must match the RAM word width.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
in_valid  in  1  producer has data
in_ready  out  1  FIFO can accept; registered
in_data  in  DW  push data
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_data  out  DW  head data
flush  in  1  synchronous discard of all contents
level  out  8  total entries held: RAM count + inflight + buffer count, range 0..130
ram_waddr  out  AW  to RAM waddr
ram_wr  out  DW  to RAM wr
ram_we  out  1  to RAM we
ram_raddr  out  AW  to RAM raddr
ram_re  out  1  to RAM re
ram_rd  in  DW  from RAM rd

Behaviour:
- Reset (rst low, asynchronous):
  - wptr = rptr = 0, ram_cnt = 0, inflight = 0, buf_cnt = 0.
  - out_valid = 0, in_ready = 0, level = 0.
  - ram_we = 0 and ram_re = 0.
  - in_ready rises on the first clk edge after release.
- Push:
  - push = in_valid && in_ready.
  - ram_we = push, ram_waddr = wptr, ram_wr = in_data.
  - wptr increments mod 128.
- Read issue:
  - issue = (ram_cnt != 0) && (buf_cnt + inflight - pop < 2).
  - ram_re = issue, ram_raddr = rptr.
  - rptr increments mod 128.
  - The inflight flag is set on the next edge.
- Return: in the cycle after issue, ram_rd is written into the output buffer tail and inflight clears, unless a new issue sets it again. ram_rd is sampled only in that cycle.
- Pop:
  - pop = out_valid && out_ready.
  - out_data is the buffer head; out_valid = (buf_cnt != 0).
  - The buffer is a 2-entry FIFO, and a simultaneous fill and drain are both honoured.
- ram_cnt_next = ram_cnt + push - issue.
- in_ready_next = (ram_cnt_next != 128).
- level counts RAM entries, the inflight read, and buffer entries.
- Collision:
  - A read is only issued to entries committed on an earlier edge.
  - When full (ram_cnt = 128, wptr == rptr), no write occurs.
  - Therefore ram_re && ram_we && ram_raddr == ram_waddr never happens. This is asserted in the bench.
- Wrap-around: pointers wrap 127 -> 0 with no special case, and order is preserved across the wrap.
- Empty/full boundaries:
  - Push at ram_cnt = 127 drives in_ready low on the next cycle.
  - A pop-induced issue at full re-opens in_ready on the next cycle.
- Latency: push in cycle N gives out_valid in N+3 (write, read issue, buffer capture).
- flush:
  - Next edge: pointers, counts and inflight go to 0 and the buffer empties.
  - out_valid becomes 0 and in_ready becomes 1.
  - flush overrides push, pop and issue in the same cycle; ram_we and ram_re are forced 0 during that cycle.
- Reset mid-operation: all contents are lost. No partial state survives.

Optional Feature:
FIFO_CTRL_BYPASS_EN.
- Defined:
  - When ram_cnt == 0, inflight == 0, and the buffer will have room (buf_cnt - pop < 2), a push writes in_data directly into the output buffer.
  - ram_we stays 0 and level includes the entry.
  - Latency from push to out_valid is 1 cycle.
  - Ordering is preserved because bypass is only taken when nothing older is in RAM or in flight.
- Undefined: every push goes through the RAM, with latency 3.

Decomposition:
- Shared package:
  - FIFO_AW = 7, FIFO_DW = 32, FIFO_DEPTH = 128, FIFO_BUF_DEPTH = 2.
  - The level width constant (8).
- Sub-module fifo_out_buf: 2-entry output buffer with fill port (from ram_rd or bypass), pop port, buf_cnt and flush.
- The top level holds the pointers, counts, issue logic and RAM port drive, and is paired with one ram_128_32 by the integrator.

Test Plan:
1. Reset then a single push of 0xDEADBEEF at cycle N, with out_ready = 1 → out_valid in N+3 with 0xDEADBEEF, or N+1 with FIFO_CTRL_BYPASS_EN; level returns to 0.
2. Push 130 incrementing words with out_ready = 0 → in_ready drops after the 130th accept, and level = 130. Then pop all → data 0..129 in order, level = 0, in_ready = 1.
3. Continuous push and pop for 300 cycles with out_ready = 1 → one word out per cycle after fill, pointers wrap twice, in-order data, no RAM collision assertion fires.
4. Random in_valid/out_ready (50%), 1000 words → scoreboard matches and level always equals the model.
5. flush asserted at level = 40 together with in_valid = 1 → next cycle out_valid = 0, level = 0, pushed word discarded. The subsequent push of 0x5 is the next output.
6. rst pulled low mid-stream at level = 60 → out_valid, in_ready and level are 0 immediately. After release in_ready = 1 and the FIFO operates from empty.
